load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: validates size/alignment, lane-aligns store data and byte
// enables, issues one bus request and sign/zero-extends the returned load data.
module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 15,
  localparam int BL  = WORD_SIZE / 8,
  localparam int OFS = $clog2(BL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] store_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WORD_SIZE-1:0] load_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [BL-1:0]        mem_be,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t         state_reg;
  logic [2:0]     funct3_reg;
  logic [OFS-1:0] ofs_reg;
  logic [7:0]     cnt_reg;

  logic [OFS-1:0]       ofs_in;
  logic [3:0]           nb_in;
  logic [WORD_SIZE-1:0] mask_in;
  logic [WORD_SIZE-1:0] wdata_in;
  logic [BL-1:0]        be_in;
  logic                 illegal;
  logic                 misaligned;

  assign ofs_in = addr[OFS-1:0];

  always_comb begin
    nb_in   = 4'd1;
    mask_in = WORD_SIZE'(64'hFF);
    case (funct3[1:0])
      2'b00:   begin nb_in = 4'd1; mask_in = WORD_SIZE'(64'hFF);        end
      2'b01:   begin nb_in = 4'd2; mask_in = WORD_SIZE'(64'hFFFF);      end
      2'b10:   begin nb_in = 4'd4; mask_in = WORD_SIZE'(64'hFFFF_FFFF); end
      default: begin nb_in = 4'd8; mask_in = '1;                        end
    endcase
    illegal = (funct3 == 3'b111) || (is_store && funct3[2]) ||
              ((WORD_SIZE == 32) && (funct3[1:0] == 2'b11));
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      2'b11:   misaligned = (addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  // Each lane is enabled when it falls inside [offset, offset + size).
  for (genvar gi = 0; gi < BL; gi++) begin : g_lane
    assign be_in[gi] = (gi >= int'(ofs_in)) && (gi < int'(ofs_in) + int'(nb_in));
  end

  assign wdata_in = (store_data & mask_in) << {ofs_in, 3'b000};

  logic [3:0]           nb_reg_c;
  logic [6:0]           sh_amt;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] left;
  logic [WORD_SIZE-1:0] ext;

  // Move selected lanes to the LSB, then push them to the MSB and shift back
  // so the extension comes out of a single logical or arithmetic shift.
  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   nb_reg_c = 4'd1;
      2'b01:   nb_reg_c = 4'd2;
      2'b10:   nb_reg_c = 4'd4;
      default: nb_reg_c = 4'd8;
    endcase
    sh_amt  = 7'(WORD_SIZE) - {nb_reg_c, 3'b000};
    shifted = mem_rdata >> {ofs_reg, 3'b000};
    left    = shifted << sh_amt;
    if (funct3_reg[2] || (funct3_reg[1:0] == 2'b11))
      ext = left >> sh_amt;
    else
      ext = WORD_SIZE'($signed(left) >>> sh_amt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      funct3_reg <= '0;
      ofs_reg    <= '0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            funct3_reg <= funct3;
            ofs_reg    <= ofs_in;
            busy       <= 1'b1;
            if (illegal || misaligned) begin
              state_reg <= ERR;
              done      <= 1'b1;
              error     <= 1'b1;
            end else begin
              state_reg <= REQ;
              cnt_reg   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[WORD_SIZE-1:OFS], {OFS{1'b0}}};
              mem_wdata <= wdata_in;
              mem_be    <= be_in;
            end
          end
        end
        REQ: begin
          // An ack in the expiry cycle still completes normally.
          if (mem_ack || (cnt_reg == 8'(TIMEOUT - 1))) begin
            if (mem_ack) begin
              state_reg <= DONE;
              if (!mem_we) load_data <= ext;
            end else begin
              state_reg <= ERR;
              error     <= 1'b1;
            end
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit (default and short timeout) and
// 64-bit instances sharing bus/operand stimulus, each started independently.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  logic        a_start, a_busy, a_done, a_error, a_req, a_we;
  logic [31:0] a_ld, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        t_start, t_busy, t_done, t_error, t_req, t_we;
  logic [31:0] t_ld, t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        w_start, w_busy, w_done, w_error, w_req, w_we;
  logic [63:0] w_ld, w_addr, w_wdata;
  logic [7:0]  w_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT(15)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .is_store(is_store), .funct3(funct3),
    .addr(addr[31:0]), .store_data(store_data[31:0]), .busy(a_busy), .done(a_done),
    .error(a_error), .load_data(a_ld), .mem_req(a_req), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_be(a_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata[31:0]));

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT(3)) u_t (
    .clk(clk), .rst(rst), .start(t_start), .is_store(is_store), .funct3(funct3),
    .addr(addr[31:0]), .store_data(store_data[31:0]), .busy(t_busy), .done(t_done),
    .error(t_error), .load_data(t_ld), .mem_req(t_req), .mem_we(t_we),
    .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_be(t_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata[31:0]));

  load_store_unit #(.WORD_SIZE(64), .TIMEOUT(15)) u_w (
    .clk(clk), .rst(rst), .start(w_start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(w_busy), .done(w_done),
    .error(w_error), .load_data(w_ld), .mem_req(w_req), .mem_we(w_we),
    .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_be(w_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({a_busy, a_done, a_error, a_req, a_we, a_be, a_ld, a_addr, a_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b done=%b req=%b be=%b ld=%h required all zero",
               a_busy, a_done, a_req, a_be, a_ld);
    end
    checks++;
    if ({t_busy, t_done, t_error, t_req, t_we, t_be, t_ld, t_addr, t_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_t: got busy=%b done=%b req=%b be=%b ld=%h required all zero",
               t_busy, t_done, t_req, t_be, t_ld);
    end
    checks++;
    if ({w_busy, w_done, w_error, w_req, w_we, w_be, w_ld, w_addr, w_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_w: got busy=%b done=%b req=%b be=%b ld=%h required all zero",
               w_busy, w_done, w_req, w_be, w_ld);
    end
    $display("reset: outputs of all instances checked");
  endtask

  task automatic test_lb;
    addr = 64'h103; funct3 = 3'b000; is_store = 1'b0; mem_rdata = 64'h80FF_FF00;
    a_start = 1'b1;
    step;
    a_start = 1'b0; mem_ack = 1'b1;
    checks++;
    if ({a_req, a_we, a_be, a_done, a_busy} !== {1'b1, 1'b0, 4'b1000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lb_req: got req=%b we=%b be=%b done=%b busy=%b required 1 0 1000 0 1",
               a_req, a_we, a_be, a_done, a_busy);
    end
    checks++;
    if (a_addr !== 32'h100) begin
      errors++;
      $display("FAIL lb_addr: got %h required 00000100", a_addr);
    end
    step;
    mem_ack = 1'b0;
    checks++;
    if ({a_done, a_error, a_req, a_be} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL lb_done: got done=%b err=%b req=%b be=%b required 1 0 0 0000",
               a_done, a_error, a_req, a_be);
    end
    checks++;
    if (a_ld !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_data: got %h required ffffff80", a_ld);
    end
    step;
    checks++;
    if ({a_done, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL lb_idle: got done=%b busy=%b required 0 0", a_done, a_busy);
    end
    $display("LB addr=103 -> load_data=%h", a_ld);
  endtask

  task automatic test_sh;
    addr = 64'h202; funct3 = 3'b001; is_store = 1'b1; store_data = 64'h1234_ABCD;
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({a_req, a_we, a_be, a_wdata, a_addr, a_done} !==
          {1'b1, 1'b1, 4'b1100, 32'hABCD_0000, 32'h200, 1'b0}) begin
        errors++;
        $display("FAIL sh_req%0d: got req=%b we=%b be=%b wdata=%h addr=%h required 1 1 1100 abcd0000 00000200",
                 k, a_req, a_we, a_be, a_wdata, a_addr);
      end
      mem_ack = (k == 3);
      step;
    end
    mem_ack = 1'b0;
    checks++;
    if ({a_done, a_error, a_req, a_be} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL sh_done: got done=%b err=%b req=%b be=%b required 1 0 0 0000",
               a_done, a_error, a_req, a_be);
    end
    checks++;
    if (a_ld !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL sh_ld_kept: got %h required ffffff80", a_ld);
    end
    step;
    $display("SH addr=202 data=1234abcd -> done after 4 REQ cycles");
  endtask

  task automatic test_errors;
    logic [2:0]  f_tab  [6] = '{3'b010, 3'b001, 3'b010, 3'b111, 3'b100, 3'b011};
    logic        s_tab  [6] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0};
    logic [63:0] a_tab  [6] = '{64'h101, 64'h201, 64'h102, 64'h0, 64'h0, 64'h0};
    for (int i = 0; i < 6; i++) begin
      funct3 = f_tab[i]; is_store = s_tab[i]; addr = a_tab[i];
      a_start = 1'b1;
      step;
      a_start = 1'b0;
      checks++;
      if ({a_done, a_error, a_req, a_busy} !== 4'b1101) begin
        errors++;
        $display("FAIL err%0d: got done=%b err=%b req=%b busy=%b required 1 1 0 1",
                 i, a_done, a_error, a_req, a_busy);
      end
      checks++;
      if (a_ld !== 32'hFFFF_FF80) begin
        errors++;
        $display("FAIL err%0d_ld: got %h required ffffff80", i, a_ld);
      end
      step;
      checks++;
      if ({a_done, a_busy, a_req} !== 3'b000) begin
        errors++;
        $display("FAIL err%0d_idle: got done=%b busy=%b req=%b required 0 0 0",
                 i, a_done, a_busy, a_req);
      end
      $display("error case %0d: funct3=%b store=%b addr=%h -> done=1 error=1",
               i, f_tab[i], s_tab[i], a_tab[i]);
    end
  endtask

  task automatic test_timeout;
    // Prime load_data with a successful LHU so the timeout must leave it alone.
    addr = 64'h2; funct3 = 3'b101; is_store = 1'b0; mem_rdata = 64'hBEEF_1234;
    t_start = 1'b1;
    step;
    t_start = 1'b0; mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    checks++;
    if ({t_done, t_error, t_ld} !== {1'b1, 1'b0, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL lhu_data: got done=%b err=%b ld=%h required 1 0 0000beef",
               t_done, t_error, t_ld);
    end
    step;
    t_start = 1'b1;
    step;
    t_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({t_req, t_be, t_done} !== {1'b1, 4'b1100, 1'b0}) begin
        errors++;
        $display("FAIL to_req%0d: got req=%b be=%b done=%b required 1 1100 0",
                 k, t_req, t_be, t_done);
      end
      step;
    end
    checks++;
    if ({t_done, t_error, t_req, t_ld} !== {1'b1, 1'b1, 1'b0, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL to_err: got done=%b err=%b req=%b ld=%h required 1 1 0 0000beef",
               t_done, t_error, t_req, t_ld);
    end
    step;
    $display("LHU addr=2 no ack -> timeout error, load_data=%h", t_ld);
  endtask

  task automatic test_ack_at_expiry;
    addr = 64'h0; funct3 = 3'b001; is_store = 1'b0; mem_rdata = 64'h0000_8001;
    t_start = 1'b1;
    step;
    t_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 2);
      step;
    end
    mem_ack = 1'b0;
    checks++;
    if ({t_done, t_error, t_ld} !== {1'b1, 1'b0, 32'hFFFF_8001}) begin
      errors++;
      $display("FAIL expiry_ack: got done=%b err=%b ld=%h required 1 0 ffff8001",
               t_done, t_error, t_ld);
    end
    step;
    $display("LH ack in last allowed cycle -> load_data=%h", t_ld);
  endtask

  task automatic test_word64;
    logic [2:0]  f_tab [4] = '{3'b011, 3'b010, 3'b110, 3'b000};
    logic        s_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] a_tab [4] = '{64'h8, 64'h4, 64'h4, 64'h5};
    logic [63:0] r_tab [4] = '{64'hDEAD_BEEF_0123_4567, 64'h8765_4321_0000_0000,
                               64'h8765_4321_0000_0000, 64'h0};
    logic [7:0]  b_tab [4] = '{8'hFF, 8'hF0, 8'hF0, 8'h20};
    logic [63:0] l_tab [4] = '{64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_8765_4321,
                               64'h0000_0000_8765_4321, 64'h0000_0000_8765_4321};
    logic [63:0] wa_tab [4] = '{64'h8, 64'h0, 64'h0, 64'h0};
    store_data = 64'h0000_0000_0000_00AB;
    for (int i = 0; i < 4; i++) begin
      funct3 = f_tab[i]; is_store = s_tab[i]; addr = a_tab[i]; mem_rdata = r_tab[i];
      w_start = 1'b1;
      step;
      w_start = 1'b0; mem_ack = 1'b1;
      checks++;
      if ({w_req, w_we, w_be, w_addr} !== {1'b1, s_tab[i], b_tab[i], wa_tab[i]}) begin
        errors++;
        $display("FAIL w64_%0d_req: got req=%b we=%b be=%h addr=%h required 1 %b %h %h",
                 i, w_req, w_we, w_be, w_addr, s_tab[i], b_tab[i], wa_tab[i]);
      end
      if (s_tab[i]) begin
        checks++;
        if (w_wdata !== 64'h0000_AB00_0000_0000) begin
          errors++;
          $display("FAIL w64_%0d_wdata: got %h required 0000ab0000000000", i, w_wdata);
        end
      end
      step;
      mem_ack = 1'b0;
      checks++;
      if ({w_done, w_error, w_ld} !== {1'b1, 1'b0, l_tab[i]}) begin
        errors++;
        $display("FAIL w64_%0d_done: got done=%b err=%b ld=%h required 1 0 %h",
                 i, w_done, w_error, w_ld, l_tab[i]);
      end
      step;
      $display("64-bit op %0d: funct3=%b addr=%h -> be=%h load_data=%h",
               i, f_tab[i], a_tab[i], b_tab[i], w_ld);
    end
  endtask

  task automatic test_start_while_busy;
    addr = 64'h1; funct3 = 3'b100; is_store = 1'b0; mem_rdata = 64'h0000_AB00;
    a_start = 1'b1;
    step;
    funct3 = 3'b111; addr = 64'h3;
    checks++;
    if ({a_req, a_be} !== {1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL busy_req: got req=%b be=%b required 1 0010", a_req, a_be);
    end
    step;
    a_start = 1'b0; mem_ack = 1'b1;
    checks++;
    if ({a_req, a_be, a_done} !== {1'b1, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL busy_hold: got req=%b be=%b done=%b required 1 0010 0", a_req, a_be, a_done);
    end
    step;
    mem_ack = 1'b0;
    checks++;
    if ({a_done, a_error, a_ld} !== {1'b1, 1'b0, 32'h0000_00AB}) begin
      errors++;
      $display("FAIL busy_done: got done=%b err=%b ld=%h required 1 0 000000ab",
               a_done, a_error, a_ld);
    end
    step;
    checks++;
    if ({a_done, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL busy_single: got done=%b busy=%b required 0 0", a_done, a_busy);
    end
    $display("LBU with extra start while busy -> single done, load_data=%h", a_ld);
  endtask

  task automatic test_reset_mid_req;
    addr = 64'h0; funct3 = 3'b000; is_store = 1'b0; mem_rdata = 64'h55;
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    checks++;
    if (a_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got req=%b required 1", a_req);
    end
    rst = 1'b0;
    step;
    rst = 1'b1;
    checks++;
    if ({a_busy, a_req, a_done, a_ld} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b req=%b done=%b ld=%h required 0 0 0 0",
               a_busy, a_req, a_done, a_ld);
    end
    mem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step;
      checks++;
      if ({a_busy, a_done, a_ld} !== '0) begin
        errors++;
        $display("FAIL rst_stray%0d: got busy=%b done=%b ld=%h required 0 0 0",
                 k, a_busy, a_done, a_ld);
      end
    end
    mem_ack = 1'b0;
    $display("reset during REQ, stray ack -> idle, no done");
  endtask

  initial begin
    rst = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
    mem_rdata = '0; mem_ack = 1'b0; a_start = 1'b0; t_start = 1'b0; w_start = 1'b0;
    step;
    step;
    test_reset;
    rst = 1'b1;
    step;
    test_lb;
    test_sh;
    test_errors;
    test_timeout;
    test_ack_at_expiry;
    test_word64;
    test_start_while_busy;
    test_reset_mid_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
